// File: rtl/bclk_divider.sv
// rtl/bclk_divider.sv - glitch-free programmable integer divider of bclk producing dclk and a rise strobe
module bclk_divider #(
  parameter int WIDTH = 8
) (
  input  logic             bclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             dclk,
  output logic             dclk_rise,
  output logic             active,
  output logic [WIDTH-1:0] cur_ratio
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur_ratio;
  logic             r_dclk;
  logic             r_dclk_rise;
  logic             r_active;

  logic [WIDTH-1:0] w_start_ratio;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_inc_high;

  // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
  assign w_start_ratio = (div_ratio < WIDTH'(2)) ? WIDTH'(2) : div_ratio;

  // High phase is floor(N/2) cycles; odd ratios put the extra cycle in the low phase.
  assign w_half     = r_cur_ratio >> 1;
  assign w_cnt_inc  = r_cnt + WIDTH'(1);
  assign w_inc_high = (w_cnt_inc < w_half);

  // Only meaningful in RUN/DRAIN, where cur_ratio is always at least 2.
  assign w_last     = (r_cnt == (r_cur_ratio - WIDTH'(1)));

  // Period sequencer: ratio and enable are only acted on at period boundaries.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cur_ratio <= '0;
      r_dclk      <= 1'b0;
      r_dclk_rise <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_cur_ratio <= w_start_ratio;
            r_dclk      <= 1'b1;
            r_dclk_rise <= 1'b1;
            r_active    <= 1'b1;
          end else begin
            r_cnt       <= '0;
            r_cur_ratio <= '0;
            r_dclk      <= 1'b0;
            r_dclk_rise <= 1'b0;
            r_active    <= 1'b0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (!w_last) begin
            // Mid-period: keep counting; a dropped enable only marks the period as the last one.
            r_cnt       <= w_cnt_inc;
            r_dclk      <= w_inc_high;
            r_dclk_rise <= 1'b0;
            if ((r_state == ST_RUN) && !en) begin
              r_state <= ST_DRAIN;
            end
          end else if ((r_state == ST_RUN) && en) begin
            // Back-to-back period: resample the ratio exactly at the rise.
            r_cnt       <= '0;
            r_cur_ratio <= w_start_ratio;
            r_dclk      <= 1'b1;
            r_dclk_rise <= 1'b1;
          end else begin
            // Period completed with no further request: park in IDLE with dclk low.
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cur_ratio <= '0;
            r_dclk      <= 1'b0;
            r_dclk_rise <= 1'b0;
            r_active    <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_cur_ratio <= '0;
          r_dclk      <= 1'b0;
          r_dclk_rise <= 1'b0;
          r_active    <= 1'b0;
        end
      endcase
    end
  end

  assign dclk      = r_dclk;
  assign dclk_rise = r_dclk_rise;
  assign active    = r_active;
  assign cur_ratio = r_cur_ratio;

endmodule

// File: tb/tb_bclk_divider.sv
// tb/tb_bclk_divider.sv - scoreboard bench for bclk_divider period, phase, strobe and reset behaviour
module tb_bclk_divider;

  localparam int WIDTH = 8;

  logic             bclk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] div_ratio;
  logic             dclk;
  logic             dclk_rise;
  logic             active;
  logic [WIDTH-1:0] cur_ratio;

  typedef struct {
    longint unsigned period_ns;
    longint unsigned high_ns;
    longint unsigned ratio;
  } exp_t;

  exp_t sb_q[$];

  int n_checks;
  int n_errors;
  int rc;

  bclk_divider #(.WIDTH(WIDTH)) u_dut (
    .bclk      (bclk),
    .rst_n     (rst_n),
    .en        (en),
    .div_ratio (div_ratio),
    .dclk      (dclk),
    .dclk_rise (dclk_rise),
    .active    (active),
    .cur_ratio (cur_ratio)
  );

  initial begin
    bclk = 1'b0;
    forever #10 bclk = ~bclk;
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int unsigned div);
    int unsigned n;
    n = (div < 2) ? 2 : div;
    sb_q.push_back('{period_ns: longint'(n) * 20, high_ns: longint'(n / 2) * 20, ratio: longint'(n)});
  endtask

  task automatic wait_rc(input int target, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge bclk);
      #2;
      if (rc >= target) break;
    end
    if (i >= budget) check(tag, longint'(rc), longint'(target));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge bclk);
      #2;
      if (!active) break;
    end
    if (i >= budget) check(tag, 64'(active), 64'd0);
  endtask

  task automatic step;
    @(posedge bclk);
    #1;
  endtask

  // Monitor: measures each dclk period from rise to next rise (or to the end of activity)
  initial begin
    logic            prev_dclk;
    logic            prev_active;
    logic            is_rise;
    logic            open;
    longint unsigned rise_t;
    longint unsigned fall_t;
    longint unsigned rise_ratio;
    exp_t            e;
    prev_dclk   = 1'b0;
    prev_active = 1'b0;
    open        = 1'b0;
    rise_t      = 0;
    fall_t      = 0;
    rise_ratio  = 0;
    rc          = 0;
    forever begin
      @(negedge bclk);
      if (!rst_n) begin
        open        = 1'b0;
        prev_dclk   = 1'b0;
        prev_active = 1'b0;
      end else begin
        is_rise = dclk && !prev_dclk;
        if (dclk_rise || is_rise) check("rise_strobe", 64'(dclk_rise), 64'(is_rise));
        if (!dclk && prev_dclk) fall_t = $time;
        if (open && (is_rise || (prev_active && !active))) begin
          if (sb_q.size() == 0) begin
            check("unexpected_period", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("period_ns", $time - rise_t, e.period_ns);
            check("high_ns", fall_t - rise_t, e.high_ns);
            check("cur_ratio", rise_ratio, e.ratio);
          end
          open = 1'b0;
        end
        if (is_rise) begin
          open       = 1'b1;
          rise_t     = $time;
          rise_ratio = 64'(cur_ratio);
          rc++;
        end
        prev_dclk   = dclk;
        prev_active = active;
      end
    end
  end

  initial begin
    int base;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    div_ratio = '0;

    // Reset state
    repeat (2) @(posedge bclk);
    #1;
    check("rst_dclk", 64'(dclk), 64'd0);
    check("rst_rise", 64'(dclk_rise), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_cur_ratio", 64'(cur_ratio), 64'd0);
    rst_n = 1'b1;
    step();
    check("idle_dclk", 64'(dclk), 64'd0);

    // 1: N=4 held, four periods, last one drained
    base = rc;
    repeat (4) push_exp(4);
    div_ratio = 8'd4;
    en = 1'b1;
    step();
    check("first_rise_latency", 64'(dclk), 64'd1);
    check("first_rise_strobe", 64'(dclk_rise), 64'd1);
    check("first_active", 64'(active), 64'd1);
    wait_rc(base + 4, 100, "timeout_t1");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t1_idle");

    // 2: N=5, then N=0 and N=1 treated as 2
    base = rc;
    repeat (3) push_exp(5);
    div_ratio = 8'd5;
    en = 1'b1;
    wait_rc(base + 3, 100, "timeout_t2a");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t2a_idle");

    base = rc;
    repeat (3) push_exp(0);
    div_ratio = 8'd0;
    en = 1'b1;
    wait_rc(base + 3, 100, "timeout_t2b");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t2b_idle");

    base = rc;
    repeat (3) push_exp(1);
    div_ratio = 8'd1;
    en = 1'b1;
    wait_rc(base + 3, 100, "timeout_t2c");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t2c_idle");

    // 3: N=6 running, ratio switched to 3 at cnt=2
    base = rc;
    push_exp(6);
    repeat (3) push_exp(3);
    div_ratio = 8'd6;
    en = 1'b1;
    wait_rc(base + 1, 100, "timeout_t3a");
    step();
    step();
    div_ratio = 8'd3;
    wait_rc(base + 4, 100, "timeout_t3b");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t3_idle");

    // 4: N=8, drop en at cnt=1; drain completes full period with no extra rise
    base = rc;
    push_exp(8);
    div_ratio = 8'd8;
    en = 1'b1;
    wait_rc(base + 1, 100, "timeout_t4");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t4_idle");
    check("drain_active", 64'(active), 64'd0);
    repeat (3) step();
    check("drain_no_rise", longint'(rc), longint'(base + 1));
    check("drain_dclk_low", 64'(dclk), 64'd0);

    // 4b: en reasserted during DRAIN is ignored until IDLE, then restarts after one IDLE cycle
    base = rc;
    repeat (2) push_exp(4);
    div_ratio = 8'd4;
    en = 1'b1;
    wait_rc(base + 1, 100, "timeout_t4b_a");
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    step();
    check("gap_idle_active", 64'(active), 64'd0);
    check("gap_idle_dclk", 64'(dclk), 64'd0);
    step();
    check("gap_restart_dclk", 64'(dclk), 64'd1);
    check("gap_restart_rise", 64'(dclk_rise), 64'd1);
    wait_rc(base + 2, 100, "timeout_t4b_b");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t4b_idle");

    // 5: asynchronous reset in the high phase, then restart on first edge
    base = rc;
    div_ratio = 8'd4;
    en = 1'b1;
    wait_rc(base + 1, 100, "timeout_t5");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_dclk", 64'(dclk), 64'd0);
    check("async_rst_rise", 64'(dclk_rise), 64'd0);
    check("async_rst_active", 64'(active), 64'd0);
    check("async_rst_cur_ratio", 64'(cur_ratio), 64'd0);
    @(negedge bclk);
    @(posedge bclk);
    #1;
    rst_n = 1'b1;
    base = rc;
    repeat (2) push_exp(4);
    step();
    check("post_rst_dclk", 64'(dclk), 64'd1);
    check("post_rst_rise", 64'(dclk_rise), 64'd1);
    check("post_rst_cur_ratio", 64'(cur_ratio), 64'd4);
    wait_rc(base + 2, 100, "timeout_t5_b");
    step();
    en = 1'b0;
    wait_idle(100, "timeout_t5_idle");

    // 6: maximum ratio 255
    base = rc;
    push_exp(255);
    div_ratio = 8'd255;
    en = 1'b1;
    wait_rc(base + 1, 100, "timeout_t6");
    step();
    en = 1'b0;
    wait_idle(600, "timeout_t6_idle");

    repeat (3) step();
    check("sb_empty", longint'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
